// File: rtl/seq_nibble_mult.sv
// Sequential 4N x 4N unsigned multiplier: feeds one nibble pair per cycle to an external
// combinational 4x4 multiplier and shift-accumulates the returned 8-bit partial products.
module seq_nibble_mult #(
    parameter int NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [4*NIBBLES-1:0] io_in_lhs,
    input  logic [4*NIBBLES-1:0] io_in_rhs,
    output logic [3:0]           io_pp_lhs,
    output logic [3:0]           io_pp_rhs,
    input  logic [7:0]           io_pp_prod,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [8*NIBBLES-1:0] io_out_data
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  j_q, j_d;
    logic [CW-1:0]  k_q, k_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [2*W-1:0] pp_shifted;

    // The pair index idx is kept split as (j, k) = (idx / NIBBLES, idx % NIBBLES), k fastest.
    always_comb begin
        io_pp_lhs = '0;
        io_pp_rhs = '0;
        if (state_q == CALC) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (j_q == CW'(n)) io_pp_lhs = a_q[4*n +: 4];
                if (k_q == CW'(n)) io_pp_rhs = b_q[4*n +: 4];
            end
        end
    end

    assign pp_shifted = (2*W)'(io_pp_prod) << (4 * (int'(j_q) + int'(k_q)));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                if (io_in_valid) begin
                    state_d = CALC;
                    a_d     = io_in_lhs;
                    b_d     = io_in_rhs;
                    acc_d   = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            CALC: begin
                acc_d = acc_q + pp_shifted;
                if (k_q == LAST) begin
                    k_d = '0;
                    if (j_q == LAST) begin
                        j_d     = '0;
                        state_d = DONE;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (io_out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake flags are registered copies of the next state, so ready/valid never combine inputs.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            j_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            j_q         <= j_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign io_in_ready  = in_ready_q;
    assign io_out_valid = out_valid_q;
    assign io_out_data  = acc_q;

endmodule

// File: tb/tb_seq_nibble_mult.sv
// Bench for seq_nibble_mult: NIBBLES=2 and NIBBLES=3 instances, each with a 4x4 product
// stand-in, checked every cycle against a transaction-level model plus literal expectations.
module tb_seq_nibble_mult;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // NIBBLES = 2 instance
    logic        v2 = 1'b0, ordy2 = 1'b0;
    logic [7:0]  l2 = '0, r2 = '0;
    logic        ir2, ov2;
    logic [3:0]  ppl2, ppr2;
    logic [7:0]  prod2;
    logic [15:0] od2;
    assign prod2 = 8'(ppl2) * 8'(ppr2);

    seq_nibble_mult #(.NIBBLES(2)) dut2 (
        .clk(clk), .reset(reset),
        .io_in_valid(v2), .io_in_ready(ir2), .io_in_lhs(l2), .io_in_rhs(r2),
        .io_pp_lhs(ppl2), .io_pp_rhs(ppr2), .io_pp_prod(prod2),
        .io_out_valid(ov2), .io_out_ready(ordy2), .io_out_data(od2)
    );

    // NIBBLES = 3 instance
    logic        v3 = 1'b0, ordy3 = 1'b0;
    logic [11:0] l3 = '0, r3 = '0;
    logic        ir3, ov3;
    logic [3:0]  ppl3, ppr3;
    logic [7:0]  prod3;
    logic [23:0] od3;
    assign prod3 = 8'(ppl3) * 8'(ppr3);

    seq_nibble_mult #(.NIBBLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .io_in_valid(v3), .io_in_ready(ir3), .io_in_lhs(l3), .io_in_rhs(r3),
        .io_pp_lhs(ppl3), .io_pp_rhs(ppr3), .io_pp_prod(prod3),
        .io_out_valid(ov3), .io_out_ready(ordy3), .io_out_data(od3)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: a request accepted in cycle T occupies the block until the
    // result (lhs*rhs) is taken; result valid from T+N*N+1, nibble pair i shown in cycle T+1+i.
    bit     m_busy [2];
    int     m_t    [2];
    longint m_a    [2];
    longint m_b    [2];

    task automatic model_step(input int d, input bit iv, input bit ir, input bit ov,
                              input longint od, input int pl, input int pr,
                              input longint il, input longint irh, input bit ordy);
        int  n, idx, el, er;
        bit  eir, eov;
        n = (d == 0) ? 2 : 3;
        if (!reset) begin
            m_busy[d] = 1'b0;
            chk($sformatf("dut%0d reset in_ready", d), longint'(ir), 1);
            chk($sformatf("dut%0d reset out_valid", d), longint'(ov), 0);
            chk($sformatf("dut%0d reset out_data", d), od, 0);
            chk($sformatf("dut%0d reset pp_lhs", d), longint'(pl), 0);
            chk($sformatf("dut%0d reset pp_rhs", d), longint'(pr), 0);
            return;
        end
        eir = !m_busy[d];
        eov = m_busy[d] && (cyc - m_t[d] >= n * n + 1);
        el = 0;
        er = 0;
        if (m_busy[d] && !eov) begin
            idx = cyc - m_t[d] - 1;
            el = int'((m_a[d] >> (4 * (idx / n))) & 15);
            er = int'((m_b[d] >> (4 * (idx % n))) & 15);
        end
        chk($sformatf("dut%0d in_ready", d), longint'(ir), longint'(eir));
        chk($sformatf("dut%0d out_valid", d), longint'(ov), longint'(eov));
        chk($sformatf("dut%0d pp_lhs", d), longint'(pl), longint'(el));
        chk($sformatf("dut%0d pp_rhs", d), longint'(pr), longint'(er));
        if (eov) chk($sformatf("dut%0d out_data", d), od, m_a[d] * m_b[d]);
        if (eir && iv) begin
            m_busy[d] = 1'b1;
            m_t[d]    = cyc;
            m_a[d]    = il;
            m_b[d]    = irh;
        end else if (eov && ordy) begin
            m_busy[d] = 1'b0;
            $display("dut%0d result: 0x%0h * 0x%0h = 0x%0h (cycle %0d)", d, m_a[d], m_b[d], od, cyc);
        end
    endtask

    always @(negedge clk) begin
        model_step(0, v2, ir2, ov2, longint'(od2), int'(ppl2), int'(ppr2),
                   longint'(l2), longint'(r2), ordy2);
        model_step(1, v3, ir3, ov3, longint'(od3), int'(ppl3), int'(ppr3),
                   longint'(l3), longint'(r3), ordy3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready2();
        int n = 0;
        while (!ir2 && n < 100) begin tick(); n++; end
        chk("dut0 wait in_ready", longint'(ir2), 1);
    endtask

    task automatic wait_valid2();
        int n = 0;
        while (!ov2 && n < 100) begin tick(); n++; end
        chk("dut0 wait out_valid", longint'(ov2), 1);
    endtask

    task automatic xact2(input logic [7:0] lhs, input logic [7:0] rhs,
                         input logic [15:0] exp, input string tag);
        int t0;
        ordy2 = 1'b1; v2 = 1'b1; l2 = lhs; r2 = rhs;
        wait_ready2();
        t0 = cyc;
        tick();
        v2 = 1'b0;
        wait_valid2();
        chk({tag, " latency"}, cyc - t0, 5);
        chk({tag, " data"}, longint'(od2), longint'(exp));
        tick();
        chk({tag, " valid drop"}, longint'(ov2), 0);
        chk({tag, " ready back"}, longint'(ir2), 1);
    endtask

    logic [3:0] seq_l [4] = '{4'hB, 4'hB, 4'hA, 4'hA};
    logic [3:0] seq_r [4] = '{4'hD, 4'hC, 4'hD, 4'hC};

    initial begin
        int t0, t1, n;
        #1 reset = 1'b0;
        repeat (3) tick();
        chk("lit reset in_ready", longint'(ir2), 1);
        chk("lit reset out_data", longint'(od2), 0);
        reset = 1'b1;

        xact2(8'h12, 8'h34, 16'h03A8, "basic");
        xact2(8'hFF, 8'hFF, 16'hFE01, "max");
        xact2(8'h00, 8'hFF, 16'h0000, "zero");

        // nibble sequencing
        ordy2 = 1'b1; v2 = 1'b1; l2 = 8'hAB; r2 = 8'hCD;
        wait_ready2();
        tick();
        v2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("seq pp_lhs", longint'(ppl2), longint'(seq_l[i]));
            chk("seq pp_rhs", longint'(ppr2), longint'(seq_r[i]));
            tick();
        end
        chk("seq valid", longint'(ov2), 1);
        chk("seq data", longint'(od2), 16'h88EF);
        tick();

        // back-pressure with an ignored request during CALC and DONE
        ordy2 = 1'b0; v2 = 1'b1; l2 = 8'h5A; r2 = 8'h3C;
        wait_ready2();
        t0 = cyc;
        tick();
        l2 = 8'h11; r2 = 8'h11;
        wait_valid2();
        chk("bp latency", cyc - t0, 5);
        for (int i = 0; i < 10; i++) begin
            chk("bp valid", longint'(ov2), 1);
            chk("bp data", longint'(od2), 16'h1518);
            chk("bp busy", longint'(ir2), 0);
            tick();
        end
        ordy2 = 1'b1; v2 = 1'b0;
        tick();
        chk("bp valid drop", longint'(ov2), 0);
        chk("bp ready back", longint'(ir2), 1);
        for (int i = 0; i < 6; i++) begin
            chk("bp once only", longint'(ov2), 0);
            tick();
        end

        // reset in the second CALC cycle
        v2 = 1'b1; l2 = 8'h77; r2 = 8'h99;
        wait_ready2();
        tick();
        v2 = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst in_ready", longint'(ir2), 1);
        chk("rst out_valid", longint'(ov2), 0);
        chk("rst out_data", longint'(od2), 0);
        chk("rst pp_lhs", longint'(ppl2), 0);
        tick();
        tick();
        reset = 1'b1;
        xact2(8'h03, 8'h05, 16'h000F, "post-reset");

        // back-to-back on NIBBLES=3 with valid held high
        ordy3 = 1'b1; v3 = 1'b1; l3 = 12'hFFF; r3 = 12'hFFF;
        n = 0;
        while (!ir3 && n < 100) begin tick(); n++; end
        t0 = cyc;
        tick();
        l3 = 12'h123; r3 = 12'h456;
        n = 0;
        while (!ov3 && n < 100) begin tick(); n++; end
        chk("b2b first latency", cyc - t0, 10);
        chk("b2b first data", longint'(od3), 24'hFFE001);
        t1 = cyc;
        tick();
        n = 0;
        while (!ov3 && n < 100) begin tick(); n++; end
        chk("b2b spacing", cyc - t1, 11);
        chk("b2b second data", longint'(od3), 24'h04EDC2);
        v3 = 1'b0;
        tick();

        // randomized traffic on both instances, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            v2    = 1'($urandom_range(0, 1));
            v3    = 1'($urandom_range(0, 1));
            ordy2 = ($urandom_range(0, 3) != 0);
            ordy3 = ($urandom_range(0, 3) != 0);
            l2 = 8'($urandom); r2 = 8'($urandom);
            l3 = 12'($urandom); r3 = 12'($urandom);
            tick();
        end
        v2 = 1'b0; v3 = 1'b0; ordy2 = 1'b1; ordy3 = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_nibble_mult.md
# seq_nibble_mult

Sequential 4·N-by-4·N unsigned multiplier built around the team's combinational 4x4 lookup multiplier (`FastMult`). It breaks each operand pair into nibbles and issues one nibble pair per cycle to the 4x4 unit. It shifts and accumulates each returned 8-bit partial product. The block sits directly around `FastMult`: it drives `FastMult`'s operand inputs and consumes its product output, with ready/valid handshakes on both the request side and the result side.

## Interface
- `NIBBLES`, default 2: nibbles per operand. Operand width is W = 4·NIBBLES; result width is 2W.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset; the block is in reset while low.
- `io_in_valid`  in  1  request valid.
- `io_in_ready`  out  1  block can accept a request.
- `io_in_lhs`  in  W  multiplicand.
- `io_in_rhs`  in  W  multiplier.
- `io_pp_lhs`  out  4  nibble to `FastMult.io_lhs`.
- `io_pp_rhs`  out  4  nibble to `FastMult.io_rhs`.
- `io_pp_prod`  in  8  `FastMult.io_out`; combinational, valid in the same cycle.
- `io_out_valid`  out  1  result valid.
- `io_out_ready`  in  1  consumer accepts the result.
- `io_out_data`  out  2W  product.

## Operation
- States:
  - IDLE: `io_in_ready` = 1.
  - CALC: `io_in_ready` = 0.
  - DONE: `io_in_ready` = 0, `io_out_valid` = 1.
- Transitions:
  - IDLE → CALC on the input handshake (`io_in_valid` & `io_in_ready`). The operands are latched into `a_q` and `b_q`, the accumulator is cleared, and the pair counter `idx` is set to 0.
  - CALC: `idx` counts 0 … NIBBLES²−1. Decompose `idx` as j = idx / NIBBLES and k = idx % NIBBLES.
    - `io_pp_lhs` = `a_q[4j+3:4j]`, `io_pp_rhs` = `b_q[4k+3:4k]`.
    - Each cycle: `acc <= acc + ({io_pp_prod} << 4·(j+k))`, computed at 2W bits.
  - CALC → DONE on the cycle with `idx` = NIBBLES²−1, after its accumulate.
  - DONE → IDLE on the output handshake (`io_out_valid` & `io_out_ready`).
- Arithmetic:
  - The accumulator is 2W bits and unsigned.
  - The final sum is < 2^(2W), so no overflow occurs and no bits are truncated.
  - `io_out_data` = `acc` and is meaningful only in DONE. It holds stable until the output handshake.
- `io_pp_lhs` and `io_pp_rhs` are 0 in IDLE and DONE.
- Latency is fixed; there is no zero-operand shortcut.
- `io_in_valid` in CALC or DONE is ignored; `io_in_lhs` and `io_in_rhs` are not sampled.
- `io_out_ready` outside DONE is ignored.
- Input acceptance and result delivery never occur in the same cycle. `io_in_ready` rises only the cycle after the output handshake.

## Timing
- Reset values:
  - State = IDLE, `io_in_ready` = 1.
  - `io_out_valid` = 0, `io_out_data` = 0.
  - `io_pp_lhs` = `io_pp_rhs` = 0.
  - `idx` = 0, `acc` = 0, `a_q` = `b_q` = 0.
- Input handshake at cycle T:
  - CALC occupies cycles T+1 … T+NIBBLES².
  - `io_out_valid` = 1 from cycle T+NIBBLES²+1.
  - Default NIBBLES=2: the request fires at T and the result is valid at T+5.
- Output handshake at cycle D: `io_out_valid` = 0 and `io_in_ready` = 1 at D+1. Peak throughput is one result per NIBBLES²+2 cycles.
- Back-pressure: DONE holds indefinitely while `io_out_ready` = 0, with `io_out_data` unchanged.
- Reset asserted in any state, including mid-CALC or DONE:
  - Immediately returns to the reset values above.
  - The in-flight result is discarded; no `io_out_valid` pulse is produced.
- Reset deassertion: the first request can be accepted on the first rising edge after release.
- All outputs except `io_pp_lhs`/`io_pp_rhs` are registered. `io_pp_*` are decoded from the state, `idx`, and the operand registers only; there is no combinational path from any input.

## Test plan
- Basic, NIBBLES=2: lhs=0x12, rhs=0x34, `io_out_ready`=1 → `io_out_valid` exactly 5 cycles after the input handshake, `io_out_data`=0x03A8, `io_in_ready` high again 1 cycle later.
- Nibble sequencing: lhs=0xAB, rhs=0xCD → `io_pp_lhs`/`io_pp_rhs` over the 4 CALC cycles = (B,D), (B,C), (A,D), (A,C); result 0x88EF.
- Max value: 0xFF × 0xFF → 0xFE01. 0x00 × 0xFF → 0x0000 with the same 5-cycle latency.
- Back-pressure and busy: hold `io_out_ready`=0 for 10 cycles → `io_out_valid` and `io_out_data` stable. A new `io_in_valid` with 0x11×0x11 during CALC and DONE is ignored. Releasing `io_out_ready` delivers the original result once only.
- Reset mid-operation: assert `reset` low in the 2nd CALC cycle → `io_out_valid`=0, `io_in_ready`=1, all outputs at reset values. After release, 0x03 × 0x05 → 0x000F.
- Back-to-back, NIBBLES=3: issue 0xFFF×0xFFF then 0x123×0x456 with `io_in_valid` held high → 0xFFE001 at T+10, then 0x04EDC2 after the next acceptance. Inter-result spacing is 11 cycles.
